// File: rtl/riscv_inst_decode_stage_pkg.sv
// Shared decode types for the RISC-V decode stage: instruction classes, opcodes,
// funct3/funct7 encodings and the XLEN-independent part of a queue entry.
package riscv_inst_decode_stage_pkg;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_S       = 3'd2,
        CLS_B       = 3'd3,
        CLS_U       = 3'd4,
        CLS_J       = 3'd5,
        CLS_CUSTOM0 = 3'd6,
        CLS_ILLEGAL = 3'd7
    } dec_class_e;

    typedef enum logic [6:0] {
        OP_R       = 7'b0110011,
        OP_I       = 7'b0010011,
        OP_S       = 7'b0100011,
        OP_B       = 7'b1100011,
        OP_U       = 7'b0010111,
        OP_J       = 7'b1101111,
        OP_CUSTOM0 = 7'b0001011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SW      = 3'b010,
        F3_SLTU    = 3'b011,
        F3_SR      = 3'b101
    } funct3_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // XLEN-wide fields (pc, imm, target) are appended by the top, since a package
    // cannot be parameterised by XLEN.
    typedef struct packed {
        dec_class_e  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        illegal;
    } dec_entry_t;

endpackage

// File: rtl/riscv_inst_decode_stage_queue.sv
// Generic DEPTH-entry synchronous FIFO used as the decode output queue.
// The caller must never push when count_o == DEPTH; flush empties it and wins over push/pop.
module riscv_dec_queue #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0],
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_data_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/riscv_inst_decode_stage.sv
// Registered RISC-V decode stage: classify, extract fields, sign-extend immediate, queue results.
// Optional RISCV_DEC_BRANCH_TARGET_EN adds out_target = pc + imm for B/J entries.
module riscv_inst_decode_stage
    import riscv_inst_decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_class,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
`ifdef RISCV_DEC_BRANCH_TARGET_EN
    output logic [XLEN-1:0]  out_target,
`endif
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        dec_entry_t      dec;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
`ifdef RISCV_DEC_BRANCH_TARGET_EN
        logic [XLEN-1:0] target;
`endif
    } q_entry_t;

    q_entry_t         new_entry, head_entry, head_vis;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    assign f3 = in_inst[14:12];
    assign f7 = in_inst[31:25];

    always_comb begin
        new_entry             = '0;
        new_entry.dec.rd      = in_inst[11:7];
        new_entry.dec.rs1     = in_inst[19:15];
        new_entry.dec.rs2     = in_inst[24:20];
        new_entry.dec.funct3  = f3;
        new_entry.dec.funct7  = f7;
        new_entry.pc          = in_pc;
        case (in_inst[6:0])
            OP_R: begin
                new_entry.dec.cls     = CLS_R;
                new_entry.dec.illegal = !(f7 == F7_BASE || f7 == F7_ALT) ||
                                        (f7 == F7_ALT && f3 != F3_ADD_SUB && f3 != F3_SR);
            end
            OP_I: begin
                new_entry.dec.cls     = CLS_I;
                new_entry.dec.illegal = (f3 == F3_SLL && f7 != F7_BASE) ||
                                        (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
                new_entry.imm         = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
            end
            OP_S: begin
                new_entry.dec.cls     = CLS_S;
                new_entry.dec.illegal = (f3 > F3_SW);
                new_entry.imm         = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
            end
            OP_B: begin
                new_entry.dec.cls     = CLS_B;
                new_entry.dec.illegal = (f3 == F3_SW || f3 == F3_SLTU);
                new_entry.imm         = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0};
            end
            OP_U: begin
                new_entry.dec.cls     = CLS_U;
                new_entry.imm         = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
            end
            OP_J: begin
                new_entry.dec.cls     = CLS_J;
                new_entry.imm         = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0};
            end
            OP_CUSTOM0: begin
                new_entry.dec.cls     = CLS_CUSTOM0;
                new_entry.dec.illegal = (f3 != F3_ADD_SUB);
            end
            default: begin
                new_entry.dec.cls     = CLS_ILLEGAL;
                new_entry.dec.illegal = 1'b1;
            end
        endcase
        if (new_entry.dec.illegal) new_entry.imm = '0;
`ifdef RISCV_DEC_BRANCH_TARGET_EN
        if (new_entry.dec.cls == CLS_B || new_entry.dec.cls == CLS_J)
            new_entry.target = in_pc + new_entry.imm;
`endif
    end

    // in_ready depends only on registered occupancy, so a full queue ignores a same-cycle pop.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    riscv_dec_queue #(
        .DEPTH   (DEPTH),
        .entry_t (q_entry_t)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (new_entry),
        .pop_i       (pop),
        .head_data_o (head_entry),
        .count_o     (count)
    );

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (push && new_entry.dec.illegal && illegal_cnt_q != '1)
            illegal_cnt_d = illegal_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) illegal_cnt_q <= '0;
        else     illegal_cnt_q <= illegal_cnt_d;
    end

    assign head_vis    = out_valid ? head_entry : '0;
    assign out_class   = head_vis.dec.cls;
    assign out_rd      = head_vis.dec.rd;
    assign out_rs1     = head_vis.dec.rs1;
    assign out_rs2     = head_vis.dec.rs2;
    assign out_funct3  = head_vis.dec.funct3;
    assign out_funct7  = head_vis.dec.funct7;
    assign out_illegal = head_vis.dec.illegal;
    assign out_imm     = head_vis.imm;
    assign out_pc      = head_vis.pc;
`ifdef RISCV_DEC_BRANCH_TARGET_EN
    assign out_target  = head_vis.target;
`endif
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_riscv_inst_decode_stage.sv
// Self-checking bench for riscv_inst_decode_stage: directed test-plan steps plus random traffic
// against a queue-based reference model; optional RISCV_DEC_BRANCH_TARGET_EN checks out_target.
module tb_riscv_inst_decode_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc, out_imm, out_pc;
    logic [2:0]       out_class, out_funct3;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [6:0]       out_funct7;
    logic [CNT_W-1:0] illegal_cnt;
`ifdef RISCV_DEC_BRANCH_TARGET_EN
    logic [XLEN-1:0]  out_target;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_inst_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal),
`ifdef RISCV_DEC_BRANCH_TARGET_EN
        .out_target(out_target),
`endif
        .illegal_cnt(illegal_cnt)
    );

    typedef struct {
        logic [2:0]      cls;
        logic [4:0]      rd, rs1, rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic            ill;
        logic [XLEN-1:0] imm, pc, tgt;
    } exp_t;

    exp_t exp_q[$];
    int   exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic longint sext(input longint v, input int bits);
        if (((v >> (bits - 1)) & 64'd1) != 0) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Reference decode written straight from the classification and immediate rules.
    function automatic exp_t ref_dec(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        exp_t e;
        longint imm = 0;
        logic [2:0] f3 = inst[14:12];
        logic [6:0] f7 = inst[31:25];
        e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
        e.f3 = f3; e.f7 = f7; e.pc = pc; e.ill = 1'b0;
        case (inst[6:0])
            7'b0110011: begin
                e.cls = 3'd0;
                e.ill = !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
            end
            7'b0010011: begin
                e.cls = 3'd1;
                e.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
                imm = sext(longint'(inst[31:20]), 12);
            end
            7'b0100011: begin
                e.cls = 3'd2;
                e.ill = (f3 > 3'd2);
                imm = sext(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
            end
            7'b1100011: begin
                e.cls = 3'd3;
                e.ill = (f3 == 3'd2 || f3 == 3'd3);
                imm = sext(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                           longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
            end
            7'b0010111: begin
                e.cls = 3'd4;
                imm = sext(longint'(inst[31:12]) * 4096, 32);
            end
            7'b1101111: begin
                e.cls = 3'd5;
                imm = sext(longint'(inst[31]) * (1 << 20) + longint'(inst[19:12]) * 4096 +
                           longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
            end
            7'b0001011: begin
                e.cls = 3'd6;
                e.ill = (f3 != 3'd0);
            end
            default: begin
                e.cls = 3'd7;
                e.ill = 1'b1;
            end
        endcase
        if (e.ill) imm = 0;
        e.imm = XLEN'(imm);
        e.tgt = (e.cls == 3'd3 || e.cls == 3'd5) ? pc + e.imm : '0;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t h;
        h = '{default: '0};
        if (exp_q.size() > 0) h = exp_q[0];
        check("out_valid", out_valid, exp_q.size() > 0);
        check("out_class", out_class, h.cls);
        check("out_rd", out_rd, h.rd);
        check("out_rs1", out_rs1, h.rs1);
        check("out_rs2", out_rs2, h.rs2);
        check("out_funct3", out_funct3, h.f3);
        check("out_funct7", out_funct7, h.f7);
        check("out_illegal", out_illegal, h.ill);
        check("out_imm", out_imm, h.imm);
        check("out_pc", out_pc, h.pc);
`ifdef RISCV_DEC_BRANCH_TARGET_EN
        check("out_target", out_target, h.tgt);
`endif
        check("illegal_cnt", illegal_cnt, exp_cnt);
    endtask

    // One clock of stimulus: update the model with this cycle's handshakes, then check after the edge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] pc,
                         input logic rdy, input logic fl);
        bit   accept, popped;
        exp_t e;
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
        #1;
        check("in_ready", in_ready, exp_q.size() < DEPTH);
        accept = v && (exp_q.size() < DEPTH);
        popped = rdy && (exp_q.size() > 0);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (popped) void'(exp_q.pop_front());
            if (accept) begin
                e = ref_dec(inst, pc);
                exp_q.push_back(e);
                if (e.ill && exp_cnt < CNT_MAX) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic reset_dut();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        check_outputs();
        check("reset_in_ready", in_ready, 1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops[7] = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011,
                               7'b0010111, 7'b1101111, 7'b0001011};
        logic [31:0] inst = $urandom();
        int sel = $urandom_range(0, 8);
        if (sel < 7) inst[6:0] = ops[sel];
        if ($urandom_range(0, 1) == 1) inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return inst;
    endfunction

    initial begin
        reset_dut();

        // ADDI x1,x2,-1
        cycle(1, 32'hFFF10093, 32'h0, 1, 0);
        check("addi_class", out_class, 1);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 2);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_illegal", out_illegal, 0);

        // SW x5,8(x6) then BEQ x0,x0,-4 back-to-back
        cycle(1, 32'h00532423, 32'h4, 1, 0);
        check("sw_class", out_class, 2);
        check("sw_rs1", out_rs1, 6);
        check("sw_rs2", out_rs2, 5);
        check("sw_imm", out_imm, 32'h8);
        cycle(1, 32'hFE000EE3, 32'h8, 1, 0);
        check("beq_class", out_class, 3);
        check("beq_imm", out_imm, 32'hFFFFFFFC);

        // JAL x1,+2048 at pc 0x100
        cycle(1, 32'h001000EF, 32'h100, 1, 0);
        check("jal_class", out_class, 5);
        check("jal_rd", out_rd, 1);
        check("jal_imm", out_imm, 32'h800);
`ifdef RISCV_DEC_BRANCH_TARGET_EN
        check("jal_target", out_target, 32'h900);
`endif

        // All-zero word, then custom-0 with funct3=1
        cycle(1, 32'h00000000, 32'h104, 1, 0);
        check("zero_class", out_class, 7);
        check("zero_imm", out_imm, 0);
        cycle(1, 32'h0000100B, 32'h108, 1, 0);
        check("cust_class", out_class, 6);
        check("cust_illegal", out_illegal, 1);
        check("cust_cnt", illegal_cnt, 2);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Backpressure: third push waits until the cycle after the first pop
        cycle(1, 32'h00000033, 32'h10, 0, 0);
        cycle(1, 32'h40000033, 32'h14, 0, 0);
        check("full_in_ready", in_ready, 0);
        cycle(1, 32'h00001033, 32'h18, 0, 0);
        check("held_head_pc", out_pc, 32'h10);
        cycle(1, 32'h00001033, 32'h18, 1, 0);
        check("after_pop_head_pc", out_pc, 32'h14);
        check("after_pop_in_ready", in_ready, 1);
        cycle(1, 32'h00001033, 32'h18, 1, 0);
        check("third_head_pc", out_pc, 32'h18);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Flush with a full queue, then flush dropping an accepted illegal word
        cycle(1, 32'h00000033, 32'h20, 0, 0);
        cycle(1, 32'h00000033, 32'h24, 0, 0);
        cycle(1, 32'h00000000, 32'h28, 0, 1);
        check("flush_full_valid", out_valid, 0);
        check("flush_full_in_ready", in_ready, 1);
        check("flush_full_cnt", illegal_cnt, 2);
        cycle(1, 32'h00000033, 32'h2C, 0, 0);
        cycle(1, 32'h00000000, 32'h30, 0, 1);
        check("flush_drop_valid", out_valid, 0);
        check("flush_drop_cnt", illegal_cnt, 2);

        // Random traffic; illegal_cnt is narrow enough here to reach saturation
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        check("cnt_saturated", illegal_cnt, CNT_MAX);
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 32'h0, 32'h0, 1, 0);

        // Reset in the middle of a stream
        cycle(1, 32'h00000000, 32'h40, 0, 0);
        cycle(1, 32'h00000033, 32'h44, 0, 0);
        reset_dut();
        check("midrst_cnt", illegal_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
